// File: rtl/rs_alu_pkg.sv
// Shared constants and opcode encodings for the ALU reservation station.
// Opcode 0 is reserved as "no op" and doubles as the idle marker on alu_op.
package rs_alu_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int ROB_TAG_W  = 4;
  localparam int OPCODE_W   = 7;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NONE = 7'd0,
    OP_ADD  = 7'd1,
    OP_SUB  = 7'd2,
    OP_AND  = 7'd3,
    OP_OR   = 7'd4,
    OP_XOR  = 7'd5,
    OP_SLL  = 7'd6,
    OP_SRL  = 7'd7,
    OP_SRA  = 7'd8,
    OP_SLT  = 7'd9,
    OP_SLTU = 7'd10,
    OP_ADDI = 7'd11,
    OP_BEQ  = 7'd12,
    OP_BNE  = 7'd13,
    OP_BLT  = 7'd14,
    OP_BGE  = 7'd15,
    OP_BLTU = 7'd16,
    OP_BGEU = 7'd17
  } alu_op_e;

endpackage

// File: rtl/rs_alu_pick_lowest.sv
// Priority encoder: index of the lowest set bit of i_vec, plus a found flag.
module rs_pick_lowest #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers renamed ops, wakes operands from two CDBs,
// and dispatches the lowest-index ready entry to the ALU each cycle.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = RS_ENTRIES,
  parameter int ROB_W   = ROB_TAG_W,
  parameter int OP_W    = OPCODE_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_vi,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qi_valid,
  input  logic             issue_qj_valid,
  input  logic [ROB_W-1:0] issue_qi,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             full_out,
  input  logic             cdb0_valid,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb0_tag,
  input  logic [ROB_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb0_val,
  input  logic [31:0]      cdb1_val,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy, r_qi_valid, r_qj_valid;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [31:0]        r_vi  [RS_SIZE];
  logic [31:0]        r_vj  [RS_SIZE];
  logic [31:0]        r_imm [RS_SIZE];
  logic [31:0]        r_pc  [RS_SIZE];
  logic [ROB_W-1:0]   r_qi  [RS_SIZE];
  logic [ROB_W-1:0]   r_qj  [RS_SIZE];
  logic [ROB_W-1:0]   r_rob [RS_SIZE];

  logic [OP_W-1:0]  r_alu_op;
  logic [31:0]      r_alu_vi, r_alu_vj, r_alu_imm, r_alu_pc;
  logic [ROB_W-1:0] r_alu_rob;

  logic [RS_SIZE-1:0] w_free_vec, w_ready_vec;
  logic [IDX_W-1:0]   w_free_idx, w_rdy_idx;
  logic               w_free_found, w_rdy_found, w_issue;
  logic [31:0]        w_fwd_vi, w_fwd_vj;
  logic               w_fwd_qi_valid, w_fwd_qj_valid;

  assign w_free_vec  = ~r_busy;
  assign w_ready_vec = r_busy & ~r_qi_valid & ~r_qj_valid;

  rs_pick_lowest #(.N(RS_SIZE)) u_pick_free (
    .i_vec(w_free_vec), .o_idx(w_free_idx), .o_found(w_free_found)
  );

  rs_pick_lowest #(.N(RS_SIZE)) u_pick_ready (
    .i_vec(w_ready_vec), .o_idx(w_rdy_idx), .o_found(w_rdy_found)
  );

  // Issue handshake: the decoder may present issue_valid only while full_out
  // is low; the op is taken at that edge. There is no back-pressure beyond
  // full_out, so an issue while full is simply dropped.
  assign full_out = ~w_free_found;
  assign w_issue  = issue_valid & ~full_out & ~clear_in;

  always_comb begin
    w_fwd_vi       = issue_vi;
    w_fwd_qi_valid = issue_qi_valid;
    w_fwd_vj       = issue_vj;
    w_fwd_qj_valid = issue_qj_valid;
    if (issue_qi_valid) begin
      if (cdb0_valid && cdb0_tag == issue_qi) begin
        w_fwd_vi       = cdb0_val;
        w_fwd_qi_valid = 1'b0;
      end else if (cdb1_valid && cdb1_tag == issue_qi) begin
        w_fwd_vi       = cdb1_val;
        w_fwd_qi_valid = 1'b0;
      end
    end
    if (issue_qj_valid) begin
      if (cdb0_valid && cdb0_tag == issue_qj) begin
        w_fwd_vj       = cdb0_val;
        w_fwd_qj_valid = 1'b0;
      end else if (cdb1_valid && cdb1_tag == issue_qj) begin
        w_fwd_vj       = cdb1_val;
        w_fwd_qj_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy     <= '0;
      r_qi_valid <= '0;
      r_qj_valid <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_vi[i]  <= '0;
        r_vj[i]  <= '0;
        r_imm[i] <= '0;
        r_pc[i]  <= '0;
        r_qi[i]  <= '0;
        r_qj[i]  <= '0;
        r_rob[i] <= '0;
      end
      r_alu_op  <= '0;
      r_alu_vi  <= '0;
      r_alu_vj  <= '0;
      r_alu_imm <= '0;
      r_alu_pc  <= '0;
      r_alu_rob <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_busy   <= '0;
        r_alu_op <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_qi_valid[i]) begin
            if (cdb0_valid && cdb0_tag == r_qi[i]) begin
              r_vi[i]       <= cdb0_val;
              r_qi_valid[i] <= 1'b0;
            end else if (cdb1_valid && cdb1_tag == r_qi[i]) begin
              r_vi[i]       <= cdb1_val;
              r_qi_valid[i] <= 1'b0;
            end
          end
          if (r_busy[i] && r_qj_valid[i]) begin
            if (cdb0_valid && cdb0_tag == r_qj[i]) begin
              r_vj[i]       <= cdb0_val;
              r_qj_valid[i] <= 1'b0;
            end else if (cdb1_valid && cdb1_tag == r_qj[i]) begin
              r_vj[i]       <= cdb1_val;
              r_qj_valid[i] <= 1'b0;
            end
          end
        end
        if (w_rdy_found) begin
          r_alu_op          <= r_op[w_rdy_idx];
          r_alu_vi          <= r_vi[w_rdy_idx];
          r_alu_vj          <= r_vj[w_rdy_idx];
          r_alu_imm         <= r_imm[w_rdy_idx];
          r_alu_pc          <= r_pc[w_rdy_idx];
          r_alu_rob         <= r_rob[w_rdy_idx];
          r_busy[w_rdy_idx] <= 1'b0;
        end else begin
          r_alu_op <= '0;
        end
        // The free slot is never the dispatching slot, so both writes coexist.
        if (w_issue) begin
          r_busy[w_free_idx]     <= 1'b1;
          r_op[w_free_idx]       <= issue_op;
          r_vi[w_free_idx]       <= w_fwd_vi;
          r_vj[w_free_idx]       <= w_fwd_vj;
          r_qi_valid[w_free_idx] <= w_fwd_qi_valid;
          r_qj_valid[w_free_idx] <= w_fwd_qj_valid;
          r_qi[w_free_idx]       <= issue_qi;
          r_qj[w_free_idx]       <= issue_qj;
          r_imm[w_free_idx]      <= issue_imm;
          r_pc[w_free_idx]       <= issue_pc;
          r_rob[w_free_idx]      <= issue_rob;
        end
      end
    end
  end

  assign alu_op  = r_alu_op;
  assign alu_vi  = r_alu_vi;
  assign alu_vj  = r_alu_vj;
  assign alu_imm = r_alu_imm;
  assign alu_pc  = r_alu_pc;
  assign alu_rob = r_alu_rob;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: issue, wakeup, forwarding, full/priority,
// flush, stall and asynchronous reset, all against hand-computed values.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk_in, rst_in, rdy_in, clear_in;
  logic        issue_valid;
  logic [6:0]  issue_op;
  logic [31:0] issue_vi, issue_vj, issue_imm, issue_pc;
  logic        issue_qi_valid, issue_qj_valid;
  logic [3:0]  issue_qi, issue_qj, issue_rob;
  logic        full_out;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic [6:0]  alu_op;
  logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
  logic [3:0]  alu_rob;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vi(issue_vi), .issue_vj(issue_vj),
    .issue_qi_valid(issue_qi_valid), .issue_qj_valid(issue_qj_valid),
    .issue_qi(issue_qi), .issue_qj(issue_qj),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob(issue_rob),
    .full_out(full_out),
    .cdb0_valid(cdb0_valid), .cdb1_valid(cdb1_valid),
    .cdb0_tag(cdb0_tag), .cdb1_tag(cdb1_tag),
    .cdb0_val(cdb0_val), .cdb1_val(cdb1_val),
    .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_op = '0; issue_vi = '0; issue_vj = '0;
    issue_qi_valid = 1'b0; issue_qj_valid = 1'b0; issue_qi = '0; issue_qj = '0;
    issue_imm = '0; issue_pc = '0; issue_rob = '0;
    cdb0_valid = 1'b0; cdb1_valid = 1'b0; cdb0_tag = '0; cdb1_tag = '0;
    cdb0_val = '0; cdb1_val = '0;
    clear_in = 1'b0;
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                             input logic qiv, input logic [3:0] qi,
                             input logic qjv, input logic [3:0] qj,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] rob);
    issue_valid = 1'b1; issue_op = op; issue_vi = vi; issue_vj = vj;
    issue_qi_valid = qiv; issue_qi = qi; issue_qj_valid = qjv; issue_qj = qj;
    issue_imm = imm; issue_pc = pc; issue_rob = rob;
  endtask

  task automatic drive_cdb0(input logic [3:0] tag, input logic [31:0] val);
    cdb0_valid = 1'b1; cdb0_tag = tag; cdb0_val = val;
  endtask

  initial begin
    logic [31:0] exp_rob;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    drive_idle();

    // reset state
    tick(); tick();
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_full", 32'(full_out), 32'd0);
    check("rst_alu_vi", alu_vi, 32'd0);
    check("rst_alu_rob", 32'(alu_rob), 32'd0);
    #2 rst_in = 1'b1;
    tick();
    check("post_rst_idle", 32'(alu_op), 32'd0);

    // ready issue: two edges to alu_op
    drive_issue(OP_ADDI, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd3, 32'h40, 4'd2);
    tick();
    drive_idle();
    check("ready_edge1_idle", 32'(alu_op), 32'd0);
    tick();
    check("ready_op", 32'(alu_op), 32'(OP_ADDI));
    check("ready_vi", alu_vi, 32'd5);
    check("ready_imm", alu_imm, 32'd3);
    check("ready_pc", alu_pc, 32'h40);
    check("ready_rob", 32'(alu_rob), 32'd2);
    tick();
    check("ready_after_idle", 32'(alu_op), 32'd0);
    check("ready_hold_vi", alu_vi, 32'd5);

    // wakeup via cdb1
    drive_issue(OP_ADD, 32'd0, 32'd10, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 32'h50, 4'd3);
    tick();
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("wake_pending_idle", 32'(alu_op), 32'd0);
    end
    cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_val = 32'h20;
    tick();
    drive_idle();
    check("wake_edge_idle", 32'(alu_op), 32'd0);
    tick();
    check("wake_op", 32'(alu_op), 32'(OP_ADD));
    check("wake_vi", alu_vi, 32'h20);
    check("wake_vj", alu_vj, 32'd10);
    check("wake_rob", 32'(alu_rob), 32'd3);
    tick();

    // same-cycle forwarding, cdb0 beats cdb1 on equal tags
    drive_issue(OP_SUB, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'd0, 32'h60, 4'd5);
    drive_cdb0(4'd4, 32'd9);
    cdb1_valid = 1'b1; cdb1_tag = 4'd4; cdb1_val = 32'h77;
    tick();
    drive_idle();
    check("fwd_edge1_idle", 32'(alu_op), 32'd0);
    tick();
    check("fwd_op", 32'(alu_op), 32'(OP_SUB));
    check("fwd_vj", alu_vj, 32'd9);
    check("fwd_vi", alu_vi, 32'd1);
    tick();

    // fill all eight entries pending on tag 1
    for (int k = 0; k < 8; k++) begin
      check("fill_not_full", 32'(full_out), 32'd0);
      drive_issue(OP_XOR, 32'd0, 32'(k), 1'b1, 4'd1, 1'b0, 4'd0, 32'd0,
                  32'h1000 + 32'(4 * k), 4'(8 + k));
      exp_q.push_back(32'(8 + k));
      tick();
    end
    drive_idle();
    check("full_set", 32'(full_out), 32'd1);
    drive_issue(OP_ADDI, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'hdead, 4'd0);
    tick();
    drive_idle();
    check("full_ignore_idle", 32'(alu_op), 32'd0);
    check("full_still", 32'(full_out), 32'd1);
    drive_cdb0(4'd1, 32'h100);
    tick();
    drive_idle();
    check("full_wake_idle", 32'(alu_op), 32'd0);
    check("full_before_disp", 32'(full_out), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_rob = exp_q.pop_front();
      check("order_rob", 32'(alu_rob), exp_rob);
      check("order_op", 32'(alu_op), 32'(OP_XOR));
      check("order_vi", alu_vi, 32'h100);
      check("order_vj", alu_vj, 32'(k));
      check("order_pc", alu_pc, 32'h1000 + 32'(4 * k));
      if (k == 0) check("full_drop", 32'(full_out), 32'd0);
    end
    tick();
    check("order_done_idle", 32'(alu_op), 32'd0);

    // flush with three ready entries and a concurrent issue
    for (int k = 0; k < 3; k++) begin
      drive_issue(OP_AND, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'd0, 4'(1 + k));
      tick();
    end
    drive_idle();
    drive_cdb0(4'd2, 32'h33);
    tick();
    drive_idle();
    clear_in = 1'b1;
    drive_issue(OP_ADDI, 32'd4, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd9);
    tick();
    drive_idle();
    check("flush_op", 32'(alu_op), 32'd0);
    check("flush_full", 32'(full_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_disp", 32'(alu_op), 32'd0);
    end

    // stall with ready entries
    for (int k = 0; k < 3; k++) begin
      drive_issue(OP_OR, 32'(k), 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0, 4'(4 + k));
      tick();
    end
    drive_idle();
    drive_cdb0(4'd3, 32'h44);
    tick();
    drive_idle();
    tick();
    check("stall_first_rob", 32'(alu_rob), 32'd4);
    rdy_in = 1'b0;
    clear_in = 1'b1;
    drive_issue(OP_SUB, 32'd7, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd15);
    drive_cdb0(4'd3, 32'h99);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_op", 32'(alu_op), 32'(OP_OR));
      check("stall_rob", 32'(alu_rob), 32'd4);
    end
    rdy_in = 1'b1;
    drive_idle();
    tick();
    check("resume_rob5", 32'(alu_rob), 32'd5);
    check("resume_vi5", alu_vi, 32'h44);
    tick();
    check("resume_rob6", 32'(alu_rob), 32'd6);
    tick();
    check("resume_idle", 32'(alu_op), 32'd0);

    // asynchronous reset mid-cycle
    drive_issue(OP_SLT, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 32'd0, 4'd7);
    tick();
    drive_issue(OP_BEQ, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd8, 32'h80, 4'd8);
    tick();
    drive_idle();
    tick();
    check("pre_rst_op", 32'(alu_op), 32'(OP_BEQ));
    #3 rst_in = 1'b0;
    #1;
    check("async_rst_op", 32'(alu_op), 32'd0);
    check("async_rst_rob", 32'(alu_rob), 32'd0);
    check("async_rst_full", 32'(full_out), 32'd0);
    #2 rst_in = 1'b1;
    tick();
    check("after_rst_idle", 32'(alu_op), 32'd0);
    drive_cdb0(4'd5, 32'h55);
    tick();
    drive_idle();
    tick();
    check("after_rst_no_disp", 32'(alu_op), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station that issues work to the combinational ALU; it is the initiator side of the ALU op/operand interface.
- Accepts renamed ALU/branch ops from the decoder and buffers up to RS_SIZE entries.
- Snoops two CDB ports to wake up pending operands.
- Dispatches one ready op per cycle to the ALU, with alu_op = 0 meaning idle.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2).
- ROB_W, 4, ROB tag width.
- OP_W, 7, opcode width; value 0 reserved as "no op".

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes all state.
- clear_in  in  1  flush on mispredict.
- issue_valid  in  1  decoder presents an op this cycle.
- issue_op  in  OP_W  opcode, nonzero.
- issue_vi, issue_vj  in  32  operand values (used when not pending).
- issue_qi_valid, issue_qj_valid  in  1  operand pending on a tag.
- issue_qi, issue_qj  in  ROB_W  producer tags.
- issue_imm, issue_pc  in  32  immediate and PC.
- issue_rob  in  ROB_W  destination ROB tag.
- full_out  out  1  no free entry; decoder must not issue.
- cdb0_valid, cdb1_valid  in  1  broadcast valid (ALU, LSB).
- cdb0_tag, cdb1_tag  in  ROB_W  broadcast tags.
- cdb0_val, cdb1_val  in  32  broadcast values.
- alu_op  out  OP_W  dispatched op; 0 means idle.
- alu_vi, alu_vj, alu_imm, alu_pc  out  32  operands to ALU.
- alu_rob  out  ROB_W  destination tag to ALU.

Behaviour:
- Reset (rst_in low, async): all entries not busy; alu_op=0; alu_vi/vj/imm/pc=0; alu_rob=0; full_out=0.
- Entry fields: busy, op, vi, vj, qi_valid, qi, qj_valid, qj, imm, pc, rob.
- Issue:
  - If issue_valid && !full_out && !clear_in, the lowest-index free entry is written at the clock edge.
  - Issue while full_out=1 is ignored; this is a decoder protocol error.
- Same-cycle forwarding at issue: if issue_qi_valid and cdbN_valid with cdbN_tag==issue_qi, the entry stores vi=cdbN_val with qi_valid=0. Same rule for qj. cdb0 has priority if both match.
- Wakeup: each cycle, every busy entry with a pending qi/qj matching a valid CDB tag captures the value and clears the pending bit. cdb0 wins ties.
- Ready: busy && !qi_valid && !qj_valid, evaluated on registered state.
  - An entry woken or issued in cycle t is first eligible in cycle t+1.
- Dispatch:
  - The lowest-index ready entry is selected. At the edge, alu_* outputs are registered from it and the entry's busy bit clears.
  - If no entry is ready, alu_op is registered to 0; other alu_* outputs hold.
  - Latency: an issued op with both operands ready appears on alu_op at the second edge after issue (issue edge, then dispatch edge).
- full_out: combinational, high when every entry is busy in registered state. Entries freed by dispatch become visible the next cycle. An issue and a dispatch may occur in the same cycle.
- clear_in (synchronous, when rdy_in high):
  - All busy bits clear and alu_op=0 at the next edge.
  - A concurrent issue is dropped.
  - CDB traffic that cycle is ignored.
- rdy_in low: no state or output changes; issue, CDB and clear inputs are ignored that cycle.
- No arithmetic in this block; values are passed through unmodified at 32 bits.

Decomposition:
- Shared const.v package: opcode defines (ADD…BGEU, with 0 meaning none), ROB_W, RS_SIZE.
- One natural sub-module, rs_pick_lowest: a parameterised priority encoder (RS_SIZE bits → index + found). It is instantiated twice, once for the free slot and once for the ready slot.

Test Plan:
- Reset: assert rst_in low mid-cycle → alu_op=0 and full_out=0 immediately; no dispatch after release until an issue occurs.
- Ready issue:
  - Stimulus: ADDI, vi=5, imm=3, rob=2, no pending operands.
  - Response: two edges later alu_op=ADDI, alu_vi=5, alu_imm=3, alu_rob=2 for one cycle, then alu_op=0.
- Wakeup:
  - Stimulus: ADD with qi=7 pending, vj=10; three cycles later cdb1 broadcasts tag 7, val 0x20.
  - Response: dispatch the cycle after the broadcast with alu_vi=0x20, alu_vj=10.
- Issue/CDB forwarding:
  - Stimulus: issue SUB with qj=4 pending in the same cycle cdb0 broadcasts tag 4, val 9.
  - Response: entry is ready at once; alu_vj=9 at the second edge.
- Full and priority:
  - Stimulus: issue 8 ops all pending on tag 1.
  - Response: full_out=1 and a 9th issue is ignored. Broadcast tag 1, then entries dispatch in index order 0..7 on consecutive cycles; full_out drops one cycle after the first dispatch.
- Flush and stall:
  - Stimulus: with 3 ready entries, pulse clear_in together with an issue.
  - Response: next cycle alu_op=0, no further dispatch, full_out=0.
  - Separately, hold rdy_in low for 5 cycles with ready entries: alu_* outputs are frozen and dispatch resumes in order afterwards.
